// File: rtl/ctrl_pkg.sv
// Shared definitions for the control unit: FSM states, IR field positions,
// class/op encodings and the packed strobe bundle.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST,
    S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_A0, S_A1, S_A2, S_A3,
    S_L0, S_L1, S_L2, S_L3,
    S_S0, S_S1, S_S2,
    S_MOV, S_IN0, S_IN1, S_OUT,
    S_HALT
  } state_t;

  localparam int IR_CLASS_BIT = 15;
  localparam int IR_OP_LSB    = 12;
  localparam int IR_RD_LSB    = 10;
  localparam int IR_RSA_LSB   = 8;
  localparam int IR_RSB_LSB   = 6;
  localparam int IR_IMM_BIT   = 5;

  localparam logic       CLASS_ALU  = 1'b0;
  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_STORE   = 3'b001;
  localparam logic [2:0] OP_MOV     = 3'b010;
  localparam logic [2:0] OP_IN      = 3'b011;
  localparam logic [2:0] OP_OUT     = 3'b100;
  localparam logic [2:0] OP_HALT    = 3'b111;

  typedef struct packed {
    logic alu_in0;
    logic alu_in1;
    logic alu_out_latch;
    logic alu_out_en;
    logic alu_imm_out;
    logic pc_out_en;
    logic pc_inc;
    logic mem_en;
    logic mem_rw;
    logic mar_in;
    logic mdr_write_en;
    logic mdr_read_en;
    logic mdr_out;
    logic p0_latch;
    logic p0_out;
    logic p1_latch;
    logic p1_out;
    logic ir_en;
    logic halted;
  } ctrl_t;

  function automatic logic [1:0] ir_field2(input logic [15:0] ir, input int lsb);
    return ir[lsb +: 2];
  endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// Combinational 2-bit register index to one-hot enable, gated by en_i.
module reg_sel_decode (
  input  logic [1:0] idx_i,
  input  logic       en_i,
  output logic [3:0] onehot_o
);

  assign onehot_o = en_i ? (4'b0001 << idx_i) : 4'b0000;

endmodule

// File: rtl/control_unit.sv
// Moore-FSM control unit: fetch/decode/execute strobes decoded from state and IR.
// Optional macro ALUI_EN: IR[5] on ALU ops selects the immediate instead of rsB in A1.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IRinstruct,
  input  logic        MFC,
  output logic        ALUin0,
  output logic        ALUin1,
  output logic        ALUOutLatch,
  output logic        ALUOutEn,
  output logic        ALUImmOut,
  output logic        PCOutEn,
  output logic        PCInc,
  output logic        r0Latch,
  output logic        r1Latch,
  output logic        r2Latch,
  output logic        r3Latch,
  output logic        r0Out,
  output logic        r1Out,
  output logic        r2Out,
  output logic        r3Out,
  output logic        memEN,
  output logic        memRW,
  output logic        MARin,
  output logic        MDRwriteEN,
  output logic        MDRreadEN,
  output logic        MDRout,
  output logic        p0Latch,
  output logic        p0Out,
  output logic        p1Latch,
  output logic        p1Out,
  output logic        IREN,
  output logic        halted
);
  import ctrl_pkg::*;

  state_t     state_q, state_d;
  ctrl_t      ctl;
  logic       src_en, src_use_rsb, rd_en;
  logic       imm_sel;
  logic [1:0] src_idx;
  logic [3:0] r_out, r_latch;
  logic [2:0] op;

  assign op = IRinstruct[IR_OP_LSB +: 3];

`ifdef ALUI_EN
  logic unused_ir;
  assign imm_sel   = IRinstruct[IR_IMM_BIT];
  assign unused_ir = ^IRinstruct[4:0];
`else
  logic unused_ir;
  assign imm_sel   = 1'b0;
  assign unused_ir = ^IRinstruct[5:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:  state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   if (MFC) state_d = S_F2;
      S_F2:   state_d = S_F3;
      S_F3:   state_d = S_DEC;
      S_DEC: begin
        if (IRinstruct[IR_CLASS_BIT] == CLASS_ALU) begin
          state_d = S_A0;
        end else begin
          case (op)
            OP_LOAD:  state_d = S_L0;
            OP_STORE: state_d = S_S0;
            OP_MOV:   state_d = S_MOV;
            OP_IN:    state_d = S_IN0;
            OP_OUT:   state_d = S_OUT;
            OP_HALT:  state_d = S_HALT;
            default:  state_d = S_F0;
          endcase
        end
      end
      S_A0:   state_d = S_A1;
      S_A1:   state_d = S_A2;
      S_A2:   state_d = S_A3;
      S_L0:   state_d = S_L1;
      S_L1:   if (MFC) state_d = S_L2;
      S_L2:   state_d = S_L3;
      S_S0:   state_d = S_S1;
      S_S1:   state_d = S_S2;
      S_S2:   if (MFC) state_d = S_F0;
      S_IN0:  state_d = S_IN1;
      S_HALT: state_d = S_HALT;
      S_A3, S_L3, S_MOV, S_IN1, S_OUT: state_d = S_F0;
      default: state_d = S_RST;
    endcase
  end

  // Register-file strobes are expressed as enables here and expanded by the decoders.
  always_comb begin
    ctl         = '0;
    src_en      = 1'b0;
    src_use_rsb = 1'b0;
    rd_en       = 1'b0;
    unique case (state_q)
      S_F0:   begin ctl.pc_out_en = 1'b1; ctl.mar_in = 1'b1; end
      S_F1:   ctl.mem_en = 1'b1;
      S_F2:   ctl.mdr_read_en = 1'b1;
      S_F3:   begin ctl.mdr_out = 1'b1; ctl.ir_en = 1'b1; ctl.pc_inc = 1'b1; end
      S_A0:   begin src_en = 1'b1; ctl.alu_in0 = 1'b1; end
      S_A1: begin
        ctl.alu_in1 = 1'b1;
        if (imm_sel) begin
          ctl.alu_imm_out = 1'b1;
        end else begin
          src_en      = 1'b1;
          src_use_rsb = 1'b1;
        end
      end
      S_A2:   ctl.alu_out_latch = 1'b1;
      S_A3:   begin ctl.alu_out_en = 1'b1; rd_en = 1'b1; end
      S_L0:   begin src_en = 1'b1; ctl.mar_in = 1'b1; end
      S_L1:   ctl.mem_en = 1'b1;
      S_L2:   ctl.mdr_read_en = 1'b1;
      S_L3:   begin ctl.mdr_out = 1'b1; rd_en = 1'b1; end
      S_S0:   begin src_en = 1'b1; ctl.mar_in = 1'b1; end
      S_S1:   begin src_en = 1'b1; src_use_rsb = 1'b1; ctl.mdr_write_en = 1'b1; end
      S_S2:   begin ctl.mem_en = 1'b1; ctl.mem_rw = 1'b1; end
      S_MOV:  begin src_en = 1'b1; rd_en = 1'b1; end
      S_IN0:  ctl.p1_latch = 1'b1;
      S_IN1:  begin ctl.p1_out = 1'b1; rd_en = 1'b1; end
      S_OUT:  begin src_en = 1'b1; ctl.p0_latch = 1'b1; end
      S_HALT: ctl.halted = 1'b1;
      default: ;
    endcase
  end

  assign src_idx = src_use_rsb ? ir_field2(IRinstruct, IR_RSB_LSB)
                               : ir_field2(IRinstruct, IR_RSA_LSB);

  reg_sel_decode u_src_dec (
    .idx_i    (src_idx),
    .en_i     (src_en),
    .onehot_o (r_out)
  );

  reg_sel_decode u_rd_dec (
    .idx_i    (ir_field2(IRinstruct, IR_RD_LSB)),
    .en_i     (rd_en),
    .onehot_o (r_latch)
  );

  assign ALUin0      = ctl.alu_in0;
  assign ALUin1      = ctl.alu_in1;
  assign ALUOutLatch = ctl.alu_out_latch;
  assign ALUOutEn    = ctl.alu_out_en;
  assign ALUImmOut   = ctl.alu_imm_out;
  assign PCOutEn     = ctl.pc_out_en;
  assign PCInc       = ctl.pc_inc;
  assign {r3Latch, r2Latch, r1Latch, r0Latch} = r_latch;
  assign {r3Out, r2Out, r1Out, r0Out}         = r_out;
  assign memEN       = ctl.mem_en;
  assign memRW       = ctl.mem_rw;
  assign MARin       = ctl.mar_in;
  assign MDRwriteEN  = ctl.mdr_write_en;
  assign MDRreadEN   = ctl.mdr_read_en;
  assign MDRout      = ctl.mdr_out;
  assign p0Latch     = ctl.p0_latch;
  assign p0Out       = ctl.p0_out;
  assign p1Latch     = ctl.p1_latch;
  assign p1Out       = ctl.p1_out;
  assign IREN        = ctl.ir_en;
  assign halted      = ctl.halted;

endmodule
